// File: rtl/adaptive_threshold_pkg.sv
// rtl/adaptive_threshold_pkg.sv - shared constants, FSM states and compare helper for adaptive_threshold
package adaptive_threshold_pkg;

  localparam logic [2:0] STATE_BOX_FILTER = 3'd1;
  localparam logic [2:0] STATE_THRESHOLD  = 3'd2;

  localparam int PIX_BITS = 8;

  localparam logic [PIX_BITS-1:0] PIX_BLACK = 8'd0;
  localparam logic [PIX_BITS-1:0] PIX_WHITE = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } thr_state_t;

  // True when pixel - mean + offset > 0, evaluated in 10-bit signed so nothing wraps.
  function automatic logic above_threshold(input logic [PIX_BITS-1:0] pix,
                                           input logic [PIX_BITS-1:0] mean,
                                           input logic [PIX_BITS-1:0] offset);
    logic [PIX_BITS+1:0] d;
    d = {2'b00, pix} - {2'b00, mean} + {2'b00, offset};
    return !d[PIX_BITS+1] && (d != '0);
  endfunction

endpackage

// File: rtl/threshold_delay_line.sv
// rtl/threshold_delay_line.sv - {valid, address} shift register aligning write addresses with read data
module threshold_delay_line #(
  parameter int DEPTH     = 2,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [ADDR_BITS-1:0] in_addr,
  output logic                 tap_valid,
  output logic                 out_valid,
  output logic [ADDR_BITS-1:0] out_addr
);

  logic [DEPTH-1:0]     valid_sr;
  logic [ADDR_BITS-1:0] addr_sr [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_sr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_sr[i] <= '0;
      end
    end else begin
      valid_sr   <= flush ? '0 : {valid_sr[DEPTH-2:0], in_valid};
      addr_sr[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

  // The stage before the output marks when read data is valid for the compare register.
  assign tap_valid = valid_sr[DEPTH-2];
  assign out_valid = valid_sr[DEPTH-1];
  assign out_addr  = addr_sr[DEPTH-1];

endmodule

// File: rtl/adaptive_threshold.sv
// rtl/adaptive_threshold.sv - binary threshold of image against local mean; ADAPTIVE_THRESHOLD_FG_COUNT_EN adds oFgCount
module adaptive_threshold
  import adaptive_threshold_pkg::*;
#(
  parameter int         WIDTH_BITS   = 8,
  parameter int         HEIGHT_BITS  = 8,
  parameter int         READ_LATENCY = 1,
  parameter logic [2:0] STATE_ID     = STATE_THRESHOLD
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              global_state,
  input  logic [PIX_BITS-1:0]     iOffset,
  output logic [WIDTH_BITS-1:0]   oImageCol,
  output logic [HEIGHT_BITS-1:0]  oImageRow,
  input  logic [PIX_BITS-1:0]     iImageData,
  output logic [WIDTH_BITS-1:0]   oMeanCol,
  output logic [HEIGHT_BITS-1:0]  oMeanRow,
  input  logic [PIX_BITS-1:0]     iMeanData,
  output logic [WIDTH_BITS-1:0]   oResultCol,
  output logic [HEIGHT_BITS-1:0]  oResultRow,
  output logic [PIX_BITS-1:0]     oResultData,
  output logic                    oResultWren,
  output logic                    finished
`ifdef ADAPTIVE_THRESHOLD_FG_COUNT_EN
  ,
  output logic [WIDTH_BITS+HEIGHT_BITS:0] oFgCount
`endif
);

  localparam int                   ADDR_BITS  = WIDTH_BITS + HEIGHT_BITS;
  localparam int                   DEPTH      = READ_LATENCY + 1;
  localparam logic [ADDR_BITS-1:0] LAST_POS   = '1;
  localparam logic [1:0]           DRAIN_LAST = 2'(READ_LATENCY);

  thr_state_t            state;
  thr_state_t            state_next;
  logic [ADDR_BITS-1:0]  pos;
  logic [PIX_BITS-1:0]   offset_q;
  logic [1:0]            drain_cnt;
  logic [PIX_BITS-1:0]   result_data;
  logic                  enabled;
  logic                  start_scan;
  logic                  push_valid;
  logic                  flush;
  logic                  tap_valid;
  logic [ADDR_BITS-1:0]  result_addr;

  assign enabled = (global_state == STATE_ID);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enabled && !finished) state_next = SCAN;
      SCAN:    if (!enabled) state_next = IDLE;
               else if (pos == LAST_POS) state_next = DRAIN;
      DRAIN:   if (!enabled) state_next = IDLE;
               else if (drain_cnt == DRAIN_LAST) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Leaving the enabled phase mid-run discards every read still in flight.
  always_comb begin
    start_scan = 1'b0;
    push_valid = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE:    start_scan = (state_next == SCAN);
      SCAN:    begin
                 push_valid = 1'b1;
                 flush      = !enabled;
               end
      DRAIN:   flush = !enabled;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos       <= '0;
      offset_q  <= '0;
      drain_cnt <= '0;
      finished  <= 1'b0;
    end else begin
      if (start_scan) begin
        pos      <= '0;
        offset_q <= iOffset;
      end else if (state == SCAN) begin
        pos <= pos + 1'b1;
      end
      if (state == SCAN) begin
        drain_cnt <= '0;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
      if (state == DRAIN && state_next == DONE) begin
        finished <= 1'b1;
      end
    end
  end

  assign oImageCol = pos[WIDTH_BITS-1:0];
  assign oImageRow = pos[ADDR_BITS-1:WIDTH_BITS];
  assign oMeanCol  = pos[WIDTH_BITS-1:0];
  assign oMeanRow  = pos[ADDR_BITS-1:WIDTH_BITS];

  threshold_delay_line #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_delay_line (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (push_valid),
    .in_addr   (pos),
    .tap_valid (tap_valid),
    .out_valid (oResultWren),
    .out_addr  (result_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_data <= PIX_BLACK;
    end else begin
      result_data <= (tap_valid && above_threshold(iImageData, iMeanData, offset_q))
                     ? PIX_WHITE : PIX_BLACK;
    end
  end

  assign oResultData = result_data;
  assign oResultCol  = result_addr[WIDTH_BITS-1:0];
  assign oResultRow  = result_addr[ADDR_BITS-1:WIDTH_BITS];

`ifdef ADAPTIVE_THRESHOLD_FG_COUNT_EN
  logic [ADDR_BITS:0] fg_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fg_count <= '0;
    end else if (start_scan) begin
      fg_count <= '0;
    end else if (oResultWren && oResultData == PIX_WHITE) begin
      fg_count <= fg_count + 1'b1;
    end
  end

  assign oFgCount = fg_count;
`endif

endmodule

// File: doc/adaptive_threshold.md
Name: adaptive_threshold

Overview:
Stage directly downstream of the 3x3 box filter; runs while global_state == 2.
- Streams every pixel of the original image and its local mean (from the box-filter result memory) in raster order.
- Writes a binary image: 255 if pixel > mean - offset, else 0.
- Throughput is one pixel per clock, pipelined over a synchronous-read memory latency.

Parameters:
- WIDTH_BITS, 8, column address width; WIDTH = 2**WIDTH_BITS.
- HEIGHT_BITS, 8, row address width; HEIGHT = 2**HEIGHT_BITS.
- READ_LATENCY, 1, clocks from address to valid read data on both source memories (1..3).
- STATE_ID, 2, global_state value that enables this stage.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- global_state  in  3  top-level phase; stage runs only when equal to STATE_ID.
- iOffset  in  8  unsigned threshold offset C; sampled on the IDLE->SCAN transition.
- oImageCol  out  WIDTH_BITS  original image read column.
- oImageRow  out  HEIGHT_BITS  original image read row.
- iImageData  in  8  original pixel, READ_LATENCY after address.
- oMeanCol  out  WIDTH_BITS  mean memory read column (always equal to oImageCol).
- oMeanRow  out  HEIGHT_BITS  mean memory read row (always equal to oImageRow).
- iMeanData  in  8  box-filter mean, READ_LATENCY after address.
- oResultCol  out  WIDTH_BITS  binary result write column.
- oResultRow  out  HEIGHT_BITS  binary result write row.
- oResultData  out  8  0 or 255.
- oResultWren  out  1  result write enable, one pulse per pixel.
- finished  out  1  sticky done flag.

Behaviour:
Reset:
- All outputs 0; state IDLE; address counter pos = 0; valid pipeline cleared.
- A reset asserted mid-run aborts immediately, with no further writes.

FSM:
- IDLE: if global_state == STATE_ID and !finished, latch iOffset, pos <= 0, go to SCAN.
- SCAN: drive pos as the read address each cycle and push {valid = 1, pos} into the delay line.
  - pos increments every cycle.
  - At pos == WIDTH*HEIGHT-1, issue that address, then go to DRAIN.
- DRAIN: issue no addresses (push valid = 0); stay READ_LATENCY+1 cycles until the delay line is empty, then go to DONE.
- DONE: finished <= 1 and hold. finished is sticky until reset; no re-run even if global_state returns to STATE_ID.

Leaving the enabled phase:
- If global_state != STATE_ID in SCAN or DRAIN: clear the delay-line valids, oResultWren = 0, go to IDLE, finished stays 0.
- Re-entry restarts from pos 0.

Addressing and timing:
- Read address = {row, col} = pos. Column is the low WIDTH_BITS, row is the high HEIGHT_BITS.
- Image and mean addresses are identical every cycle.
- Latency: address issued at cycle t → oResultWren = 1 with the matching address and data at cycle t+READ_LATENCY+1 (registered compare stage).
- First write occurs READ_LATENCY+1 cycles after SCAN entry.
- Exactly WIDTH*HEIGHT write pulses, no gaps, strictly increasing addresses.
- finished rises the cycle after the last write.

Arithmetic:
- d = {2'b0, pixel} - {2'b0, mean} + {2'b0, offset}, computed as 10-bit signed.
- oResultData = (d > 0) ? 255 : 0.
- No wrap or saturation: offset 255 with mean 0 gives d = pixel + 255, so the output is 255.
- Pixel == mean with offset 0 gives 0 (strict inequality).

Optional Feature:
ADAPTIVE_THRESHOLD_FG_COUNT_EN
- Defined:
  - Adds output oFgCount, width WIDTH_BITS+HEIGHT_BITS+1.
  - Counts write pulses with data 255.
  - Cleared on reset and on the IDLE->SCAN transition.
  - Final value is stable when finished rises.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package:
  - Global phase constants (STATE_BOX_FILTER = 1, STATE_THRESHOLD = 2).
  - FSM state typedef {IDLE, SCAN, DRAIN, DONE}.
  - Pixel width constant (8).
  - Binary levels PIX_BLACK = 0, PIX_WHITE = 255.
- One sub-module: threshold_delay_line, a parameterised shift register of {valid, address} of depth READ_LATENCY+1, with a synchronous flush input.

Test Plan:
- WIDTH_BITS = HEIGHT_BITS = 2, READ_LATENCY = 1, image ramp 0..15, mean all 8, offset 0 → 16 writes, addresses 0..15 in order. Data is 0 for pixels 0..8 and 255 for pixels 9..15. finished is high 1 cycle after the address-15 write.
- Pixel 100, mean 110, offset 10 → 0; offset 11 → 255. Pixel 0, mean 0, offset 255 → 255. Pixel 255, mean 255, offset 0 → 0.
- READ_LATENCY = 3 → first oResultWren 4 cycles after SCAN entry. Drive the memory model with matching latency; all 16 results correct; no bubbles.
- Drop global_state to 1 after 5 writes → oResultWren low within 1 cycle, finished = 0. Return to 2 → full 16-write rerun starting from address 0.
- Assert reset mid-SCAN → all outputs 0 asynchronously. After release with global_state = 2, a full run completes. After finished, toggling global_state 2→0→2 produces no writes.
- With ADAPTIVE_THRESHOLD_FG_COUNT_EN defined, the ramp case → oFgCount = 7 at finished.
